// File: rtl/slc3_mem_arbiter_if.sv
// Request/response bundle for the two SRAM requesters: the SLC-3 CPU memory port
// and the debug/init port. The arbiter connects through the slave modport.
interface slc3_mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;

    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_wdata;
    logic [15:0] dbg_rdata;
    logic        dbg_ready;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ready
    );
endinterface

// File: rtl/slc3_mem_arbiter.sv
// Round-robin arbiter sharing the external 16-bit SRAM between the CPU and the
// debug/init port; sequences each multi-cycle read/write and drives the SRAM pins.
module slc3_mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [3:0]  ADDR_HI     = 4'b0000
) (
    input  logic               Clk,
    input  logic               Reset,
    slc3_mem_arbiter_if.slave  bus,
    output logic               busy,
    output logic               grant_dbg,
    output logic               CE,
    output logic               OE,
    output logic               WE,
    output logic               UB,
    output logic               LB,
    output logic [19:0]        ADDR,
    inout  wire  [15:0]        Data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_dbg_q, grant_dbg_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dbg_rdata_q, dbg_rdata_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        dbg_ready_q, dbg_ready_d;
    logic        busy_q, busy_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        drive_q, drive_d;
    logic        pick_dbg;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_dbg_d = grant_dbg_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        pick_dbg    = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the port that lost the previous grant wins.
                if (bus.cpu_req || bus.dbg_req) begin
                    pick_dbg    = bus.dbg_req && (!bus.cpu_req || !grant_dbg_q);
                    grant_dbg_d = pick_dbg;
                    addr_d      = {ADDR_HI, pick_dbg ? bus.dbg_addr : bus.cpu_addr};
                    wdata_d     = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                    cnt_d       = '0;
                    state_d     = (pick_dbg ? bus.dbg_we : bus.cpu_we) ? WR_SETUP : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = RD_DONE;
                    if (grant_dbg_q) begin
                        dbg_rdata_d = Data;
                    end else begin
                        cpu_rdata_d = Data;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = '0;
            end
            WR_PULSE: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pin and handshake outputs are decoded from the next state so they are registered.
        busy_d      = (state_d != IDLE);
        ce_n_d      = !(state_d inside {RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD});
        oe_n_d      = (state_d != RD_WAIT);
        we_n_d      = (state_d != WR_PULSE);
        drive_d     = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
        cpu_ready_d = (state_d inside {RD_DONE, WR_HOLD}) && !grant_dbg_d;
        dbg_ready_d = (state_d inside {RD_DONE, WR_HOLD}) && grant_dbg_d;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_dbg_q <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_dbg_q <= grant_dbg_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            dbg_ready_q <= dbg_ready_d;
            busy_q      <= busy_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            drive_q     <= drive_d;
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.dbg_ready = dbg_ready_q;
    assign busy          = busy_q;
    assign grant_dbg     = grant_dbg_q;
    assign CE            = ce_n_q;
    assign OE            = oe_n_q;
    assign WE            = we_n_q;
    assign UB            = ce_n_q;
    assign LB            = ce_n_q;
    assign ADDR          = addr_q;
    assign Data          = drive_q ? wdata_q : 16'bz;

endmodule

// File: doc/slc3_mem_arbiter.md
Name: slc3_mem_arbiter

Overview:
Shares the single 16-bit external SRAM between two requesters: the SLC-3 CPU memory port (MAR/MDR fetch, load and store traffic) and the debug/init port (program loader and memory monitor). It arbitrates requests and sequences each multi-cycle SRAM read or write. It drives the active-low SRAM strobes and the bidirectional data bus. It sits inside the memory subsystem, between the datapath's MAR/MDR and the SRAM pins.

Parameters:
WAIT_CYCLES, 2, cycles OE (read) or WE (write) is held asserted; legal range 1..15.
ADDR_HI, 4'b0000, upper 4 bits of the 20-bit SRAM address.

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request; held until cpu_ready
cpu_we  in  1  1 = write, 0 = read; sampled at grant
cpu_addr  in  16  word address (MAR)
cpu_wdata  in  16  write data (MDR)
cpu_rdata  out  16  registered read data
cpu_ready  out  1  one-cycle completion pulse
dbg_req  in  1  debug/init access request; held until dbg_ready
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  16  word address
dbg_wdata  in  16  write data
dbg_rdata  out  16  registered read data
dbg_ready  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE
grant_dbg  out  1  owner of current/last access (0 = CPU, 1 = debug)
CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active-low
ADDR  out  20  SRAM address
Data  inout  16  SRAM data bus

Behaviour:
- Reset (asynchronous, Reset = 0):
  - state = IDLE; CE, OE, WE, UB and LB = 1; Data = Hi-Z; ADDR = 0.
  - cpu_rdata = dbg_rdata = 0; both ready outputs = 0; busy = 0.
  - grant_dbg = 1, so the CPU wins the first tie.
  - A reset in any state aborts the access at once. No ready pulse is issued for an aborted access.
- States: IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - Requests are sampled only in IDLE. Strobes are deasserted and Data is Hi-Z.
  - One request pending: grant it.
  - Both pending: grant the port that did not win the previous grant (round-robin via grant_dbg).
  - At the grant edge, latch addr, we and wdata of the winner and update grant_dbg.
  - Next state is RD_WAIT if we = 0, else WR_SETUP.
- RD_WAIT:
  - CE = OE = UB = LB = 0; ADDR = {ADDR_HI, addr}.
  - Counter runs WAIT_CYCLES cycles. Data is sampled into the winner's rdata register on the last edge.
  - Next state is RD_DONE.
- RD_DONE: one cycle.
  - Strobes are deasserted; the winner's ready = 1 and its rdata is valid.
  - Next state is IDLE.
- WR_SETUP: one cycle.
  - CE = UB = LB = 0, WE = 1; ADDR valid; Data driven with the latched wdata.
- WR_PULSE: WE = 0 for WAIT_CYCLES cycles; address and data held.
- WR_HOLD: one cycle.
  - WE = 1, CE still 0; Data still driven; the winner's ready = 1.
  - Next state is IDLE.
- Latency from the grant edge:
  - Read: ready is high in cycle WAIT_CYCLES+1.
  - Write: ready is high in cycle WAIT_CYCLES+2.
  - The IDLE cycle after each access means back-to-back requests see one idle bubble between accesses.
- rdata registers hold their value until the next completed read for the same port. A write never changes rdata.
- Data is driven only in WR_SETUP, WR_PULSE and WR_HOLD. OE and WE are never both 0.
- The losing requester keeps its request held and is served next. Maximum wait is one full access.
- A request dropped before its grant is ignored. Changes to we, addr or wdata after the grant have no effect.
- If a requester is still asserting req during its ready cycle, that is treated as a new request at the next IDLE.

Test Plan:
- Reset held 0 with both req = 1 -> CE/OE/WE = 1, Data Hi-Z, busy = 0, no ready pulses. Release Reset -> CPU granted first (grant_dbg = 0).
- dbg write addr 0x0074, data 0x1234 (WAIT_CYCLES = 2) -> ADDR = 0x00074, WE low exactly 2 cycles with Data = 0x1234 stable, dbg_ready pulses at cycle 4 after grant. Then a CPU read of 0x0074 -> cpu_rdata = 0x1234 with cpu_ready at cycle 3.
- cpu_req and dbg_req asserted in the same cycle and held for 4 accesses -> grants alternate CPU, dbg, CPU, dbg; exactly one ready per access.
- Reset pulsed low mid WR_PULSE -> WE and CE return to 1 asynchronously, Data Hi-Z, no dbg_ready. A fresh write afterwards completes normally.
- CPU read 0x0075 with SRAM model returning 0xBEEF, then a CPU write 0x0075 = 0x0000 -> cpu_rdata stays 0xBEEF after the write.
- Across all scenarios the bench checks continuously -> OE and WE never both 0, and Data driven only while WE-phase states are active.
